// File: rtl/ibex_mem_responder.sv
// rtl/ibex_mem_responder.sv - memory-side responder for the Ibex req/gnt/rvalid bus
// Word RAM with byte-enable writes, fixed response latency and bounded outstanding requests.
module ibex_mem_responder #(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int unsigned MemWords       = 256,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [6:0]  rdata_intg_o,
    output logic        err_o,
    output logic [1:0]  outstanding_o
);

    localparam int unsigned AddrW    = $clog2(MemWords);
    localparam logic [31:0] MemBytes = 32'(MemWords * 4);
    localparam logic [1:0]  MaxOut   = 2'(MaxOutstanding);
    localparam int unsigned Last     = RespLatency - 1;

    // Check bits of prim_secded_inv_39_32_enc: Hsiao parities, then bits 1/3/5 inverted.
    function automatic logic [6:0] intg_enc(input logic [31:0] d);
        logic [6:0] c;
        c[0] = ^(d & 32'h2606_BD25);
        c[1] = ^(d & 32'hDEBA_8050);
        c[2] = ^(d & 32'h413D_89AA);
        c[3] = ^(d & 32'h3123_4ED1);
        c[4] = ^(d & 32'hC2C1_323B);
        c[5] = ^(d & 32'h2DCC_624C);
        c[6] = ^(d & 32'h9850_5586);
        return c ^ 7'h2A;
    endfunction

    logic [31:0]            mem [MemWords];
    logic [1:0]             cnt_q;
    logic [RespLatency-1:0] vld_q;
    logic [RespLatency-1:0] err_q;
    logic [31:0]            dat_q [RespLatency];

    logic [31:0]      offset;
    logic             in_range;
    logic [AddrW-1:0] idx;
    logic             accept;

    // Unsigned subtraction makes addresses below the base wrap far out of range.
    assign offset   = addr_i - MemBase;
    assign in_range = offset < MemBytes;
    assign idx      = offset[AddrW+1:2];
    assign gnt_o    = req_i & ~stall_i & (cnt_q < MaxOut);
    assign accept   = req_i & gnt_o;

    // RAM contents survive reset, so this process has no reset branch.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem[idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            err_q[0] <= accept & ~in_range;
            dat_q[0] <= (accept && !we_i && in_range) ? mem[idx] : 32'h0;
            for (int i = 1; i < RespLatency; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 2'd0;
        end else begin
            case ({accept, rvalid_o})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Idle stages carry zero data and no error, so the outputs need no masking.
    assign rvalid_o      = vld_q[Last];
    assign err_o         = err_q[Last];
    assign rdata_o       = dat_q[Last];
    assign rdata_intg_o  = intg_enc(rdata_o);
    assign outstanding_o = cnt_q;

endmodule
